// File: rtl/radiation_pkg.sv
// Shared types and constants for the synthetic pulse emitter family.
package radiation_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          CNT_W        = 16;

  // One right-shifting Galois step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/radiation_lfsr.sv
// 16-bit Galois LFSR with a step enable; shared by the pulse, noise and
// pile-up generators. An all-zero seed would lock up, so it becomes 1.
module radiation_lfsr
  import radiation_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        step,
  output logic [15:0] state
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;

  // Advance the sequence only when asked.
  always_comb begin
    lfsr_d = step ? lfsr_next(lfsr_q) : lfsr_q;
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= SEED_EFF;
    else         lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/radiation_pulse_emitter.sv
// Synthetic detector-pulse source: emits height/timestamp events on a
// valid/ready stream at a programmable interval, with fixed or LFSR heights.
module radiation_pulse_emitter
  import radiation_pkg::*;
#(
  parameter int          HEIGHT_WIDTH   = 16,
  parameter int          INTERVAL_WIDTH = 16,
  parameter int          TS_WIDTH       = 32,
  parameter logic [15:0] LFSR_SEED      = DEFAULT_SEED
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic                      random_mode,
  input  logic [INTERVAL_WIDTH-1:0] interval_period,
  input  logic [HEIGHT_WIDTH-1:0]   fixed_height,
  input  logic [HEIGHT_WIDTH-1:0]   height_mask,
  input  logic                      clear_counts,
  output logic                      pulse_valid,
  input  logic                      pulse_ready,
  output logic [HEIGHT_WIDTH-1:0]   pulse_height,
  output logic [TS_WIDTH-1:0]       pulse_timestamp,
  output logic [CNT_W-1:0]          pulse_count,
  output logic [CNT_W-1:0]          drop_count,
  output logic                      busy
);

  // Drop counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // A zero height would look like "no event" downstream, so it is bumped to 1.
  function automatic logic [HEIGHT_WIDTH-1:0] nonzero_height(input logic [HEIGHT_WIDTH-1:0] h);
    return (h == '0) ? HEIGHT_WIDTH'(1) : h;
  endfunction

  state_e                    state_q, state_d;
  logic [INTERVAL_WIDTH-1:0] cnt_q, cnt_d;
  logic [TS_WIDTH-1:0]       ts_q, ts_d;
  logic                      valid_q, valid_d;
  logic [HEIGHT_WIDTH-1:0]   height_q, height_d;
  logic [TS_WIDTH-1:0]       stamp_q, stamp_d;
  logic [CNT_W-1:0]          pcnt_q, pcnt_d;
  logic [CNT_W-1:0]          dcnt_q, dcnt_d;

  logic                      handshake;
  logic                      expiry;
  logic [INTERVAL_WIDTH-1:0] period_m1;
  logic                      lfsr_step;
  logic [15:0]               lfsr_state;
  logic [HEIGHT_WIDTH-1:0]   raw_height;

  assign handshake  = valid_q && pulse_ready;
  // A programmed interval of 0 behaves as 1, i.e. a reload value of 0.
  assign period_m1  = (interval_period == '0) ? '0 : interval_period - INTERVAL_WIDTH'(1);
  assign lfsr_step  = (state_q != IDLE);
  assign raw_height = random_mode ? (lfsr_state[HEIGHT_WIDTH-1:0] & height_mask) : fixed_height;

  radiation_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .step   (lfsr_step),
    .state  (lfsr_state)
  );

  // Sequencing and slot interval counter; expiries only occur in RUN with enable held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    expiry  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          cnt_d   = period_m1;
        end
      end
      RUN: begin
        if (!enable) begin
          // A pulse still waiting for ready must be delivered before going idle.
          state_d = (valid_q && !pulse_ready) ? DRAIN : IDLE;
        end else if (cnt_q == '0) begin
          expiry = 1'b1;
          cnt_d  = period_m1;
        end else begin
          cnt_d = cnt_q - INTERVAL_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream register, counters and timestamp; a held pulse is never overwritten.
  always_comb begin
    ts_d     = ts_q + TS_WIDTH'(1);
    valid_d  = valid_q;
    height_d = height_q;
    stamp_d  = stamp_q;
    pcnt_d   = pcnt_q;
    dcnt_d   = dcnt_q;
    if (expiry) begin
      if (!valid_q || handshake) begin
        valid_d  = 1'b1;
        height_d = nonzero_height(raw_height);
        stamp_d  = ts_q;
      end else begin
        dcnt_d = sat_inc(dcnt_q);
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
    if (handshake) pcnt_d = pcnt_q + CNT_W'(1);
    if (clear_counts) begin
      pcnt_d = '0;
      dcnt_d = '0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output and counter registers; all cleared on reset so the stream starts quiet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ts_q     <= '0;
      valid_q  <= 1'b0;
      height_q <= '0;
      stamp_q  <= '0;
      pcnt_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      ts_q     <= ts_d;
      valid_q  <= valid_d;
      height_q <= height_d;
      stamp_q  <= stamp_d;
      pcnt_q   <= pcnt_d;
      dcnt_q   <= dcnt_d;
    end
  end

  assign pulse_valid     = valid_q;
  assign pulse_height    = height_q;
  assign pulse_timestamp = stamp_q;
  assign pulse_count     = pcnt_q;
  assign drop_count      = dcnt_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_radiation_pulse_emitter.sv
// Bench for radiation_pulse_emitter: directed scenarios with literal
// expectations plus a randomized run checked against a behavioural model.
module tb_radiation_pulse_emitter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        random_mode = 1'b0;
  logic [15:0] interval_period = 16'd0;
  logic [15:0] fixed_height = 16'd0;
  logic [15:0] height_mask = 16'd0;
  logic        clear_counts = 1'b0;
  logic        pulse_ready = 1'b0;
  logic        pulse_valid;
  logic [15:0] pulse_height;
  logic [31:0] pulse_timestamp;
  logic [15:0] pulse_count;
  logic [15:0] drop_count;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  radiation_pulse_emitter dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .random_mode     (random_mode),
    .interval_period (interval_period),
    .fixed_height    (fixed_height),
    .height_mask     (height_mask),
    .clear_counts    (clear_counts),
    .pulse_valid     (pulse_valid),
    .pulse_ready     (pulse_ready),
    .pulse_height    (pulse_height),
    .pulse_timestamp (pulse_timestamp),
    .pulse_count     (pulse_count),
    .drop_count      (drop_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The emitter is "active" from enable until disabled; while "draining" it only
  // waits for the held pulse to be taken. Slots are tracked as absolute cycle times.
  bit          m_active, m_draining;
  logic        m_valid;
  logic [15:0] m_height, m_pc, m_dc, m_lfsr;
  logic [31:0] m_stamp, m_ts;
  longint      m_cyc = 0;
  longint      m_next_slot = 0;

  function automatic logic [15:0] galois(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task model_reset();
    m_active = 0; m_draining = 0; m_valid = 0;
    m_height = 0; m_stamp = 0; m_pc = 0; m_dc = 0;
    m_lfsr = 16'hACE1; m_ts = 0;
  endtask

  task model_step();
    bit          hs, slot, was_running;
    longint      p;
    logic [15:0] h;
    hs = m_valid && pulse_ready;
    slot = 0;
    was_running = m_active || m_draining;
    p = (interval_period == 0) ? 1 : longint'(interval_period);
    if (!was_running) begin
      if (enable) begin
        m_active = 1;
        m_next_slot = m_cyc + p;
      end
    end else if (m_active) begin
      if (!enable) begin
        m_active = 0;
        m_draining = m_valid && !pulse_ready;
      end else if (m_cyc == m_next_slot) begin
        slot = 1;
        m_next_slot = m_cyc + p;
      end
    end else if (hs) begin
      m_draining = 0;
    end
    if (slot) begin
      if (!m_valid || hs) begin
        h = random_mode ? (m_lfsr & height_mask) : fixed_height;
        if (h == 0) h = 1;
        m_valid = 1; m_height = h; m_stamp = m_ts;
      end else if (m_dc != 16'hFFFF) begin
        m_dc = m_dc + 1;
      end
    end else if (hs) begin
      m_valid = 0;
    end
    if (hs) m_pc = m_pc + 1;
    if (clear_counts) begin m_pc = 0; m_dc = 0; end
    if (was_running) m_lfsr = galois(m_lfsr);
    m_ts = m_ts + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else begin
        model_step();
        m_cyc++;
      end
    end
  end

  // Compare the DUT against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("model valid", pulse_valid, m_valid);
        check("model busy", busy, m_active || m_draining);
        check("model pulse_count", pulse_count, m_pc);
        check("model drop_count", drop_count, m_dc);
        if (m_valid) begin
          check("model height", pulse_height, m_height);
          check("model timestamp", pulse_timestamp, m_stamp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    enable = 1'b0;
    clear_counts = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!pulse_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!pulse_valid) check({name, " wait timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int          seen[$];
    logic [31:0] stamps[$];
    logic [15:0] heights[$];
    logic [15:0] hold_h;
    logic [31:0] hold_t;

    repeat (3) @(negedge clk);
    check("reset valid", pulse_valid, 0);
    check("reset busy", busy, 0);
    check("reset timestamp", pulse_timestamp, 0);
    check("reset pulse_count", pulse_count, 0);
    resetn = 1'b1;
    cmp_on = 1'b1;

    // Fixed height, P=4, ready high.
    @(negedge clk);
    interval_period = 16'd4; fixed_height = 16'h0123; random_mode = 1'b0;
    pulse_ready = 1'b1; enable = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pulse_valid) begin
        seen.push_back(k);
        stamps.push_back(pulse_timestamp);
        check("fixed height", pulse_height, 16'h0123);
      end
    end
    check("fixed pulse slots", seen.size(), 3);
    if (seen.size() == 3) begin
      check("fixed slot 1", seen[0], 4);
      check("fixed slot 2", seen[1], 8);
      check("fixed slot 3", seen[2], 12);
      check("fixed ts spacing", stamps[1] - stamps[0], 4);
    end
    check("fixed pulse_count", pulse_count, 3);

    // P=0 acts as 1: continuous valid, Galois heights from the seed.
    do_reset();
    interval_period = 16'd0; random_mode = 1'b1; height_mask = 16'hFFFF;
    pulse_ready = 1'b1; enable = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("p0 valid", pulse_valid, 1);
      if (pulse_height == 16'h0) check("p0 height nonzero", pulse_height, 1);
      heights.push_back(pulse_height);
      stamps.push_back(pulse_timestamp);
    end
    check("p0 height 0", heights[0], 16'hACE1);
    check("p0 height 1", heights[1], 16'hE270);
    check("p0 height 2", heights[2], 16'h7138);
    check("p0 ts step", stamps[stamps.size()-1] - stamps[stamps.size()-2], 1);

    // Backpressure on P=2: held pulse frozen, drops counted.
    do_reset();
    interval_period = 16'd2; random_mode = 1'b0; fixed_height = 16'h0055;
    pulse_ready = 1'b0; enable = 1'b1;
    wait_valid("bp", 20);
    hold_h = pulse_height;
    hold_t = pulse_timestamp;
    repeat (10) @(negedge clk);
    check("bp height frozen", pulse_height, hold_h);
    check("bp ts frozen", pulse_timestamp, hold_t);
    check("bp drop_count", drop_count, 5);
    check("bp valid held", pulse_valid, 1);
    pulse_ready = 1'b1;
    @(negedge clk);
    check("bp pulse_count", pulse_count, 1);
    check("bp valid after hs", pulse_valid, 0);

    // Disable with a pending pulse: drain, then idle.
    pulse_ready = 1'b0;
    wait_valid("drain", 20);
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("drain busy", busy, 1);
      check("drain valid held", pulse_valid, 1);
    end
    pulse_ready = 1'b1;
    @(negedge clk);
    check("drain busy after hs", busy, 0);
    repeat (5) begin
      @(negedge clk);
      check("drain no more valid", pulse_valid, 0);
    end

    // Zero mask: every height becomes 1; clear beats a same-cycle handshake.
    @(negedge clk);
    interval_period = 16'd3; random_mode = 1'b1; height_mask = 16'h0000;
    pulse_ready = 1'b1; enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wait_valid("mask0", 20);
      check("mask0 height", pulse_height, 1);
      @(negedge clk);
    end
    wait_valid("clear", 20);
    clear_counts = 1'b1;
    @(negedge clk);
    clear_counts = 1'b0;
    check("clear pulse_count", pulse_count, 0);
    check("clear drop_count", drop_count, 0);

    // Asynchronous reset while a pulse is held.
    @(negedge clk);
    interval_period = 16'd1; pulse_ready = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("async valid", pulse_valid, 0);
    check("async busy", busy, 0);
    check("async timestamp", pulse_timestamp, 0);
    check("async height", pulse_height, 0);
    check("async pulse_count", pulse_count, 0);
    check("async drop_count", drop_count, 0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    random_mode = 1'b1; height_mask = 16'hFFFF; pulse_ready = 1'b1; enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reseed first height", pulse_height, 16'hACE1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      pulse_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) == 0) interval_period = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0) random_mode = ~random_mode;
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0:       height_mask = 16'hFFFF;
          1:       height_mask = 16'h000F;
          2:       height_mask = 16'h0000;
          default: height_mask = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 29) == 0)
        fixed_height = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      clear_counts = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    clear_counts = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
